// File: rtl/timeout_scheduler.sv
// timeout_scheduler: shares one timebase tick among NUM_CH countdown channels.
// Start requests are granted round-robin (one per cycle). Each channel counts
// qualified ticks down to expiry, and the shared timebase is enabled only while
// some channel is running.

module timeout_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick_in,
  input  logic             load,
  input  logic [CNT_W-1:0] load_count,
  input  logic             cancel,
  output logic             busy,
  output logic             busy_nxt,
  output logic             done_pulse
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_e;

  st_e              st_q, st_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             done_d;

  // state, remaining count and done pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= IDLE;
      remain_q   <= '0;
      done_pulse <= 1'b0;
    end else begin
      st_q       <= st_d;
      remain_q   <= remain_d;
      done_pulse <= done_d;
    end
  end

  // next state: cancel beats an expiring tick; load only while idle
  always_comb begin
    st_d     = st_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    if (st_q == RUN) begin
      if (cancel) begin
        st_d     = IDLE;
        remain_d = '0;
      end else if (enable && tick_in) begin
        if (remain_q == CNT_W'(1)) begin
          st_d     = IDLE;
          remain_d = '0;
          done_d   = 1'b1;
        end else begin
          remain_d = remain_q - CNT_W'(1);
        end
      end
    end else if (load) begin
      // a zero count expires immediately, alongside the ack
      if (load_count == '0) begin
        done_d = 1'b1;
      end else begin
        st_d     = RUN;
        remain_d = load_count;
      end
    end
  end

  assign busy     = (st_q == RUN);
  assign busy_nxt = (st_d == RUN);
endmodule

module timeout_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       tick_in,
  input  logic [NUM_CH-1:0]          start_req,
  input  logic [NUM_CH*CNT_W-1:0]    start_count,
  input  logic [NUM_CH-1:0]          cancel,
  output logic [NUM_CH-1:0]          start_ack,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH-1:0]          done_pulse,
  output logic                       timer_enable,
  output logic [$clog2(NUM_CH)-1:0]  grant_ptr
);
  localparam int PTR_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_arr;
  logic [NUM_CH-1:0]            elig, gnt_oh, busy_nxt;
  logic                         gnt_vld;
  logic [PTR_W-1:0]             gnt_idx;
  int                           idx;

  assign cnt_arr = start_count;
  // a channel still showing its ack this cycle must not be granted twice
  assign elig    = start_req & ~busy & ~start_ack;

  // round-robin search starting at grant_ptr, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(grant_ptr) + k) % NUM_CH;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  // one-hot grant vector feeding the channel load strobes
  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  // ack, priority pointer and timebase enable registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_ack    <= '0;
      grant_ptr    <= '0;
      timer_enable <= 1'b0;
    end else begin
      start_ack    <= gnt_oh;
      if (gnt_vld)
        grant_ptr  <= (gnt_idx == PTR_W'(NUM_CH-1)) ? '0 : gnt_idx + PTR_W'(1);
      timer_enable <= enable & (|busy_nxt);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timeout_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .tick_in    (tick_in),
      .load       (gnt_oh[g]),
      .load_count (cnt_arr[g]),
      .cancel     (cancel[g]),
      .busy       (busy[g]),
      .busy_nxt   (busy_nxt[g]),
      .done_pulse (done_pulse[g])
    );
  end
endmodule
